// File: rtl/header_encode.sv
`default_nettype none
// ============================================================================
// Module   : header_encode
// Brief    : MPEG-2 sequence / GOP / picture header generator emitting
//            (value, length) tokens with byte-aligned start codes.
//            Define HEADER_ENCODE_QUANT_MATRIX_EN to stream quant matrices.
// Revision : 1.0 - initial release
// ============================================================================
module header_encode #(
    parameter logic [3:0]  ASPECT_RATIO    = 4'h2,
    parameter logic [3:0]  FRAME_RATE_CODE = 4'h4,
    parameter logic [17:0] BIT_RATE        = 18'd20000,
    parameter logic [9:0]  VBV_SIZE        = 10'd112,
    parameter logic [7:0]  PROFILE_LEVEL   = 8'h48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Start_Header_Encode_I,
    output logic        Done_Header_Encode_O,
    input  logic        Insert_Seq_I,
    input  logic        Insert_Gop_I,
    input  logic [11:0] Horizontal_Size,
    input  logic [11:0] Vertical_Size,
    input  logic        progressive_sequence,
    input  logic [1:0]  chroma_format,
    input  logic [24:0] time_code,
    input  logic        closed_gop,
    input  logic [9:0]  temporal_reference,
    input  logic [2:0]  picture_coding_type,
    input  logic [15:0] f_codes,
    input  logic [1:0]  intra_dc_precision,
    input  logic [1:0]  picture_structure,
    input  logic [8:0]  pic_flags,
    input  logic        load_intra_quant_matrix,
    input  logic        load_non_intra_quant_matrix,
    output logic        Quant_Matrix_Read_En_O,
    output logic [6:0]  Quant_Matrix_Addr_O,
    input  logic [7:0]  Quant_Matrix_Value_I,
    output logic [31:0] Bits_Data_O,
    output logic [5:0]  Bits_Len_O,
    output logic        Bits_Valid_O,
    input  logic        Bits_Ready_I
);

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_SEQ_HDR    = 4'd1;
    localparam logic [3:0] c_ST_Q_INTRA    = 4'd2;
    localparam logic [3:0] c_ST_NI_FLAG    = 4'd3;
    localparam logic [3:0] c_ST_Q_NONINTRA = 4'd4;
    localparam logic [3:0] c_ST_SEQ_EXT    = 4'd5;
    localparam logic [3:0] c_ST_GOP        = 4'd6;
    localparam logic [3:0] c_ST_PIC_HDR    = 4'd7;
    localparam logic [3:0] c_ST_PIC_EXT    = 4'd8;
    localparam logic [3:0] c_ST_FIN        = 4'd9;

    localparam logic [31:0] c_SC_SEQ = 32'h000001B3;
    localparam logic [31:0] c_SC_EXT = 32'h000001B5;
    localparam logic [31:0] c_SC_GOP = 32'h000001B8;
    localparam logic [31:0] c_SC_PIC = 32'h00000100;

`ifdef HEADER_ENCODE_QUANT_MATRIX_EN
    localparam logic c_QM_EN = 1'b1;
`else
    localparam logic c_QM_EN = 1'b0;
`endif

    logic        r_valid;
    logic [31:0] r_data;
    logic [5:0]  r_len;
    logic [3:0]  r_state;
    logic [2:0]  r_step;
    logic [2:0]  r_bitpos;

    logic        r_ins_gop;
    logic [11:0] r_hsize;
    logic [11:0] r_vsize;
    logic        r_prog_seq;
    logic [1:0]  r_chroma;
    logic [24:0] r_time_code;
    logic        r_closed_gop;
    logic [9:0]  r_temp_ref;
    logic [2:0]  r_pic_type;
    logic [15:0] r_f_codes;
    logic [1:0]  r_dc_prec;
    logic [1:0]  r_pic_struct;
    logic [8:0]  r_pic_flags;
    logic        r_ld_intra;
    logic        r_ld_nonintra;

    logic        w_xfer;
    logic        w_slot_free;
    logic        w_start;
    logic [2:0]  w_bitpos_eff;
    logic        w_has_sc;
    logic [31:0] w_sc_code;
    logic [31:0] w_tok_data;
    logic [5:0]  w_tok_len;
    logic        w_tok_last;
    logic        w_tok_hold;
    logic [3:0]  w_next_state;
    logic        w_type_pb;
    logic        w_type_b;

    assign w_xfer       = r_valid & Bits_Ready_I;
    assign w_slot_free  = ~r_valid | Bits_Ready_I;
    assign w_start      = Start_Header_Encode_I & (r_state == c_ST_IDLE);
    // Bit position including the token leaving this cycle, so alignment
    // decisions see every bit already committed to the packer.
    assign w_bitpos_eff = r_bitpos + (w_xfer ? r_len[2:0] : 3'd0);
    assign w_type_pb    = (r_pic_type == 3'd2) | (r_pic_type == 3'd3);
    assign w_type_b     = (r_pic_type == 3'd3);

    always_comb begin
        w_has_sc  = 1'b1;
        w_sc_code = c_SC_EXT;
        case (r_state)
            c_ST_SEQ_HDR:               w_sc_code = c_SC_SEQ;
            c_ST_GOP:                   w_sc_code = c_SC_GOP;
            c_ST_PIC_HDR:               w_sc_code = c_SC_PIC;
            c_ST_SEQ_EXT, c_ST_PIC_EXT: w_sc_code = c_SC_EXT;
            default:                    w_has_sc  = 1'b0;
        endcase
    end

    always_comb begin
        w_tok_data = 32'h0;
        w_tok_len  = 6'd1;
        w_tok_last = 1'b0;
        w_tok_hold = 1'b0;
        if (w_has_sc && (r_step == 3'd0)) begin
            if (w_bitpos_eff != 3'd0) begin
                w_tok_len  = 6'd8 - {3'd0, w_bitpos_eff};
                w_tok_hold = 1'b1;
            end else begin
                w_tok_data = w_sc_code;
                w_tok_len  = 6'd32;
            end
        end else begin
            case (r_state)
                c_ST_SEQ_HDR: begin
                    case (r_step)
                        3'd1: begin w_tok_data = {8'h0, r_hsize, r_vsize}; w_tok_len = 6'd24; end
                        3'd2: begin w_tok_data = {24'h0, ASPECT_RATIO, FRAME_RATE_CODE}; w_tok_len = 6'd8; end
                        3'd3: begin w_tok_data = {2'b0, BIT_RATE, 1'b1, VBV_SIZE, 1'b0}; w_tok_len = 6'd30; end
                        default: begin w_tok_data = {31'h0, r_ld_intra}; w_tok_last = 1'b1; end
                    endcase
                end
                c_ST_NI_FLAG: begin
                    w_tok_data = {31'h0, r_ld_nonintra};
                    w_tok_last = 1'b1;
                end
                c_ST_SEQ_EXT: begin
                    if (r_step == 3'd1) begin
                        w_tok_data = {4'h1, PROFILE_LEVEL, r_prog_seq, r_chroma, 4'h0, 12'h0, 1'b1};
                        w_tok_len  = 6'd32;
                    end else begin
                        w_tok_len  = 6'd16;
                        w_tok_last = 1'b1;
                    end
                end
                c_ST_GOP: begin
                    w_tok_data = {5'h0, r_time_code, r_closed_gop, 1'b0};
                    w_tok_len  = 6'd27;
                    w_tok_last = 1'b1;
                end
                c_ST_PIC_HDR: begin
                    // Steps 2/3 carry the forward/backward f_code fields only
                    // when the picture type needs them, else extra_bit_picture.
                    if (r_step == 3'd1) begin
                        w_tok_data = {3'h0, r_temp_ref, r_pic_type, 16'hFFFF};
                        w_tok_len  = 6'd29;
                    end else if ((r_step == 3'd2 && w_type_pb) || (r_step == 3'd3 && w_type_b)) begin
                        w_tok_data = 32'h7;
                        w_tok_len  = 6'd4;
                    end else begin
                        w_tok_last = 1'b1;
                    end
                end
                c_ST_PIC_EXT: begin
                    if (r_step == 3'd1) begin
                        w_tok_data = {8'h0, 4'h8, r_f_codes, r_dc_prec, r_pic_struct};
                        w_tok_len  = 6'd24;
                    end else begin
                        w_tok_data = {22'h0, r_pic_flags, 1'b0};
                        w_tok_len  = 6'd10;
                        w_tok_last = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            c_ST_SEQ_HDR:    w_next_state = r_ld_intra ? c_ST_Q_INTRA : c_ST_NI_FLAG;
            c_ST_Q_INTRA:    w_next_state = c_ST_NI_FLAG;
            c_ST_NI_FLAG:    w_next_state = r_ld_nonintra ? c_ST_Q_NONINTRA : c_ST_SEQ_EXT;
            c_ST_Q_NONINTRA: w_next_state = c_ST_SEQ_EXT;
            c_ST_SEQ_EXT:    w_next_state = r_ins_gop ? c_ST_GOP : c_ST_PIC_HDR;
            c_ST_GOP:        w_next_state = c_ST_PIC_HDR;
            c_ST_PIC_HDR:    w_next_state = c_ST_PIC_EXT;
            c_ST_PIC_EXT:    w_next_state = c_ST_FIN;
            default:         w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_start) begin
            r_ins_gop     <= Insert_Gop_I;
            r_hsize       <= Horizontal_Size;
            r_vsize       <= Vertical_Size;
            r_prog_seq    <= progressive_sequence;
            r_chroma      <= chroma_format;
            r_time_code   <= time_code;
            r_closed_gop  <= closed_gop;
            r_temp_ref    <= temporal_reference;
            r_pic_type    <= picture_coding_type;
            r_f_codes     <= f_codes;
            r_dc_prec     <= intra_dc_precision;
            r_pic_struct  <= picture_structure;
            r_pic_flags   <= pic_flags;
            r_ld_intra    <= load_intra_quant_matrix & c_QM_EN;
            r_ld_nonintra <= load_non_intra_quant_matrix & c_QM_EN;
        end
    end

`ifdef HEADER_ENCODE_QUANT_MATRIX_EN
    logic [1:0] r_qphase;
    logic [5:0] r_idx;
    logic       r_rd_en;
    logic [6:0] r_addr;

    assign Quant_Matrix_Read_En_O = r_rd_en;
    assign Quant_Matrix_Addr_O    = r_addr;
`else
    wire w_unused_qm = &{1'b0, Quant_Matrix_Value_I};

    assign Quant_Matrix_Read_En_O = 1'b0;
    assign Quant_Matrix_Addr_O    = 7'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_step   <= 3'd0;
            r_bitpos <= 3'd0;
            r_valid  <= 1'b0;
            r_data   <= 32'h0;
            r_len    <= 6'd0;
`ifdef HEADER_ENCODE_QUANT_MATRIX_EN
            r_qphase <= 2'd0;
            r_idx    <= 6'd0;
            r_rd_en  <= 1'b0;
            r_addr   <= 7'd0;
`endif
        end else begin
            if (w_xfer) begin
                r_bitpos <= r_bitpos + r_len[2:0];
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_step  <= 3'd0;
                        r_state <= Insert_Seq_I ? c_ST_SEQ_HDR :
                                   (Insert_Gop_I ? c_ST_GOP : c_ST_PIC_HDR);
                    end
                end
                c_ST_FIN: begin
                    if (w_slot_free) begin
                        r_valid <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
`ifdef HEADER_ENCODE_QUANT_MATRIX_EN
                // Each entry: issue the read once the output slot has drained,
                // wait out the RAM latency, then present the value.
                c_ST_Q_INTRA, c_ST_Q_NONINTRA: begin
                    case (r_qphase)
                        2'd0: begin
                            if (w_slot_free) begin
                                r_valid  <= 1'b0;
                                r_rd_en  <= 1'b1;
                                r_addr   <= {(r_state == c_ST_Q_NONINTRA), r_idx};
                                r_qphase <= 2'd1;
                            end
                        end
                        2'd1: begin
                            r_rd_en  <= 1'b0;
                            r_qphase <= 2'd2;
                        end
                        default: begin
                            r_valid  <= 1'b1;
                            r_data   <= {24'h0, Quant_Matrix_Value_I};
                            r_len    <= 6'd8;
                            r_qphase <= 2'd0;
                            r_idx    <= r_idx + 6'd1;
                            if (r_idx == 6'd63) begin
                                r_state <= w_next_state;
                            end
                        end
                    endcase
                end
`endif
                default: begin
                    if (w_slot_free) begin
                        r_valid <= 1'b1;
                        r_data  <= w_tok_data;
                        r_len   <= w_tok_len;
                        if (w_tok_last) begin
                            r_state <= w_next_state;
                            r_step  <= 3'd0;
                        end else if (!w_tok_hold) begin
                            r_step  <= r_step + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign Done_Header_Encode_O = (r_state == c_ST_IDLE);
    assign Bits_Valid_O         = r_valid;
    assign Bits_Data_O          = r_data;
    assign Bits_Len_O           = r_len;

endmodule
`default_nettype wire

// File: tb/tb_header_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_header_encode
// Brief    : Scoreboard bench for header_encode (token stream, stalls,
//            alignment, reset abort; matrix streaming when the macro is set).
// Revision : 1.0 - initial release
// ============================================================================
module tb_header_encode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Start_Header_Encode_I = 1'b0;
    logic        Done_Header_Encode_O;
    logic        Insert_Seq_I = 1'b0;
    logic        Insert_Gop_I = 1'b0;
    logic [11:0] Horizontal_Size = 12'd0;
    logic [11:0] Vertical_Size = 12'd0;
    logic        progressive_sequence = 1'b0;
    logic [1:0]  chroma_format = 2'd0;
    logic [24:0] time_code = 25'd0;
    logic        closed_gop = 1'b0;
    logic [9:0]  temporal_reference = 10'd0;
    logic [2:0]  picture_coding_type = 3'd1;
    logic [15:0] f_codes = 16'd0;
    logic [1:0]  intra_dc_precision = 2'd0;
    logic [1:0]  picture_structure = 2'd0;
    logic [8:0]  pic_flags = 9'd0;
    logic        load_intra_quant_matrix = 1'b0;
    logic        load_non_intra_quant_matrix = 1'b0;
    logic        Quant_Matrix_Read_En_O;
    logic [6:0]  Quant_Matrix_Addr_O;
    logic [7:0]  Quant_Matrix_Value_I = 8'h0;
    logic [31:0] Bits_Data_O;
    logic [5:0]  Bits_Len_O;
    logic        Bits_Valid_O;
    logic        Bits_Ready_I = 1'b1;

    always #5 clock = ~clock;

    header_encode dut (
        .clock                       (clock),
        .reset                       (reset),
        .Start_Header_Encode_I       (Start_Header_Encode_I),
        .Done_Header_Encode_O        (Done_Header_Encode_O),
        .Insert_Seq_I                (Insert_Seq_I),
        .Insert_Gop_I                (Insert_Gop_I),
        .Horizontal_Size             (Horizontal_Size),
        .Vertical_Size               (Vertical_Size),
        .progressive_sequence        (progressive_sequence),
        .chroma_format               (chroma_format),
        .time_code                   (time_code),
        .closed_gop                  (closed_gop),
        .temporal_reference          (temporal_reference),
        .picture_coding_type         (picture_coding_type),
        .f_codes                     (f_codes),
        .intra_dc_precision          (intra_dc_precision),
        .picture_structure           (picture_structure),
        .pic_flags                   (pic_flags),
        .load_intra_quant_matrix     (load_intra_quant_matrix),
        .load_non_intra_quant_matrix (load_non_intra_quant_matrix),
        .Quant_Matrix_Read_En_O      (Quant_Matrix_Read_En_O),
        .Quant_Matrix_Addr_O         (Quant_Matrix_Addr_O),
        .Quant_Matrix_Value_I        (Quant_Matrix_Value_I),
        .Bits_Data_O                 (Bits_Data_O),
        .Bits_Len_O                  (Bits_Len_O),
        .Bits_Valid_O                (Bits_Valid_O),
        .Bits_Ready_I                (Bits_Ready_I)
    );

    typedef struct {
        logic [31:0] d;
        logic [5:0]  l;
    } tok_t;

    tok_t        exp_q[$];
    tok_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          m_bitpos = 0;
    int          tok_idx = 0;
    int          rd_cnt = 0;
    int          exp_rd_cnt = 0;
    logic [6:0]  rd_exp = 7'd0;
    bit          stall_prev = 1'b0;
    bit          done_pending = 1'b0;
    logic [31:0] prev_d = 32'h0;
    logic [5:0]  prev_l = 6'd0;

`ifdef HEADER_ENCODE_QUANT_MATRIX_EN
    localparam int c_ABORT_WAIT = 30;
`else
    localparam int c_ABORT_WAIT = 8;
`endif

    // Quant-matrix RAM model: entry at address a holds a, one-cycle read latency.
    always @(posedge clock) begin
        if (Quant_Matrix_Read_En_O) begin
            Quant_Matrix_Value_I <= {1'b0, Quant_Matrix_Addr_O};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_tok(input logic [31:0] d, input int l);
        tok_t t;
        t.d = d;
        t.l = 6'(l);
        exp_q.push_back(t);
        m_bitpos = (m_bitpos + l) % 8;
    endtask

    task automatic push_sc(input logic [31:0] code);
        if (m_bitpos != 0) push_tok(32'h0, 8 - m_bitpos);
        push_tok(code, 32);
    endtask

    task automatic model_frame(input bit seq, input bit gop, input bit li, input bit lni);
        if (seq) begin
            push_sc(32'h000001B3);
            push_tok({8'h0, Horizontal_Size, Vertical_Size}, 24);
            push_tok({24'h0, 4'h2, 4'h4}, 8);
            push_tok({2'b0, 18'd20000, 1'b1, 10'd112, 1'b0}, 30);
            push_tok({31'h0, li}, 1);
            if (li) for (int i = 0; i < 64; i++) push_tok(32'(i), 8);
            push_tok({31'h0, lni}, 1);
            if (lni) for (int i = 0; i < 64; i++) push_tok(32'(64 + i), 8);
            push_sc(32'h000001B5);
            push_tok({4'h1, 8'h48, progressive_sequence, chroma_format, 4'h0, 12'h0, 1'b1}, 32);
            push_tok(32'h0, 16);
        end
        if (gop) begin
            push_sc(32'h000001B8);
            push_tok({5'h0, time_code, closed_gop, 1'b0}, 27);
        end
        push_sc(32'h00000100);
        push_tok({3'h0, temporal_reference, picture_coding_type, 16'hFFFF}, 29);
        if (picture_coding_type == 3'd2 || picture_coding_type == 3'd3) push_tok(32'h7, 4);
        if (picture_coding_type == 3'd3) push_tok(32'h7, 4);
        push_tok(32'h0, 1);
        push_sc(32'h000001B5);
        push_tok({8'h0, 4'h8, f_codes, intra_dc_precision, picture_structure}, 24);
        push_tok({22'h0, pic_flags, 1'b0}, 10);
    endtask

    task automatic start_frame(input bit seq, input bit gop, input logic [2:0] ptype,
                               input bit li, input bit lni);
        bit mli;
        bit mlni;
        Insert_Seq_I                = seq;
        Insert_Gop_I                = gop;
        Horizontal_Size             = 12'd720;
        Vertical_Size               = 12'd480;
        progressive_sequence        = 1'($urandom_range(0, 1));
        chroma_format               = 2'd1;
        time_code                   = 25'($urandom);
        closed_gop                  = 1'($urandom_range(0, 1));
        temporal_reference          = 10'($urandom);
        picture_coding_type         = ptype;
        f_codes                     = 16'($urandom);
        intra_dc_precision          = 2'($urandom);
        picture_structure           = 2'd3;
        pic_flags                   = 9'($urandom);
        load_intra_quant_matrix     = li;
        load_non_intra_quant_matrix = lni;
`ifdef HEADER_ENCODE_QUANT_MATRIX_EN
        mli  = li;
        mlni = lni;
`else
        mli  = 1'b0;
        mlni = 1'b0;
`endif
        rd_exp     = mli ? 7'd0 : 7'd64;
        rd_cnt     = 0;
        exp_rd_cnt = 64 * (int'(mli) + int'(mlni));
        model_frame(seq, gop, mli, mlni);
        @(posedge clock); #1;
        Start_Header_Encode_I = 1'b1;
        @(posedge clock); #1;
        Start_Header_Encode_I = 1'b0;
        // Inputs changing after the start cycle must not affect the frame.
        Insert_Seq_I                = ~seq;
        Insert_Gop_I                = ~gop;
        Horizontal_Size             = 12'($urandom);
        Vertical_Size               = 12'($urandom);
        progressive_sequence        = ~progressive_sequence;
        chroma_format               = 2'($urandom);
        time_code                   = 25'($urandom);
        closed_gop                  = ~closed_gop;
        temporal_reference          = 10'($urandom);
        picture_coding_type         = (ptype == 3'd1) ? 3'd3 : 3'd1;
        f_codes                     = 16'($urandom);
        pic_flags                   = ~pic_flags;
        load_intra_quant_matrix     = ~li;
        load_non_intra_quant_matrix = ~lni;
        chk("busy_done_low", {63'h0, Done_Header_Encode_O}, 64'h0);
    endtask

    task automatic wait_done(input bit rnd, input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && Done_Header_Encode_O === 1'b1) && n < 5000) begin
            @(posedge clock); #1;
            Bits_Ready_I = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        chk({tag, "_no_timeout"}, {63'h0, (n < 5000)}, 64'h1);
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
        chk({tag, "_done"}, {63'h0, Done_Header_Encode_O}, 64'h1);
        chk({tag, "_read_count"}, 64'(rd_cnt), 64'(exp_rd_cnt));
        exp_q.delete();
        Bits_Ready_I = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_done"},  {63'h0, Done_Header_Encode_O}, 64'h1);
        chk({tag, "_valid"}, {63'h0, Bits_Valid_O}, 64'h0);
        chk({tag, "_data"},  {32'h0, Bits_Data_O}, 64'h0);
        chk({tag, "_len"},   {58'h0, Bits_Len_O}, 64'h0);
        chk({tag, "_rden"},  {63'h0, Quant_Matrix_Read_En_O}, 64'h0);
        chk({tag, "_addr"},  {57'h0, Quant_Matrix_Addr_O}, 64'h0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            stall_prev   = 1'b0;
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                chk("done_after_last", {62'h0, Done_Header_Encode_O, Bits_Valid_O}, 64'h2);
                done_pending = 1'b0;
            end
            if (stall_prev) begin
                chk("stall_hold", {25'h0, Bits_Valid_O, Bits_Len_O, Bits_Data_O},
                    {25'h0, 1'b1, prev_l, prev_d});
            end
            if (Bits_Valid_O && Bits_Ready_I) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_token observed data=%h len=%0d expected none",
                           Bits_Data_O, Bits_Len_O);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("token%0d", tok_idx), {26'h0, Bits_Len_O, Bits_Data_O},
                        {26'h0, mon_e.l, mon_e.d});
                    tok_idx++;
                    if (exp_q.size() == 0) done_pending = 1'b1;
                end
            end
            stall_prev = Bits_Valid_O && !Bits_Ready_I;
            prev_d     = Bits_Data_O;
            prev_l     = Bits_Len_O;
            if (Quant_Matrix_Read_En_O) begin
                chk("rd_addr", {57'h0, Quant_Matrix_Addr_O}, {57'h0, rd_exp});
                rd_exp = rd_exp + 7'd1;
                rd_cnt++;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset("por");
        reset = 1'b0;

        start_frame(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        wait_done(1'b0, "full_I");

        start_frame(1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
        wait_done(1'b0, "pic_B");

        start_frame(1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        wait_done(1'b0, "pic_P_align");

        start_frame(1'b1, 1'b1, 3'd1, 1'b1, 1'b1);
        wait_done(1'b1, "full_I_stall_qm");

        start_frame(1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        wait_done(1'b1, "gop_B_stall");

        start_frame(1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
        repeat (c_ABORT_WAIT) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset("abort");
        reset    = 1'b0;
        exp_q.delete();
        m_bitpos = 0;

        start_frame(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        wait_done(1'b0, "after_abort");

        repeat (3) @(posedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
